// File: rtl/sort_pkg.sv
// Shared types and constants for the 4-element sort unit and its downstream blocks.
// Element 0 (smallest) lives in the MSBs of a vector.
package sort_pkg;

    localparam int unsigned SORT_NBITS  = 8;
    localparam int unsigned SORT_NELEMS = 4;

    typedef logic [SORT_NBITS-1:0]             elem_t;
    typedef logic [SORT_NELEMS*SORT_NBITS-1:0] vec_t;

    typedef enum logic [1:0] {
        ELEM0 = 2'd0,
        ELEM1 = 2'd1,
        ELEM2 = 2'd2,
        ELEM3 = 2'd3
    } elem_idx_e;

    function automatic elem_t get_elem(vec_t v, int unsigned i);
        return v[(SORT_NELEMS-1-i)*SORT_NBITS +: SORT_NBITS];
    endfunction

endpackage

// File: rtl/sort_out_serializer_if.sv
// Vector input / element stream output bundle of sort_out_serializer.
// master = serializer side, slave = upstream producer plus downstream consumer.
interface sort_out_serializer_if #(
    parameter int unsigned nbits = sort_pkg::SORT_NBITS
);

    logic [sort_pkg::SORT_NELEMS*nbits-1:0] in_;
    logic                                   in_val;
    logic [nbits-1:0]                       out;
    logic                                   out_val;
    logic                                   out_rdy;
    logic                                   out_last;
    logic                                   overflow;

    modport master (
        input  in_, in_val, out_rdy,
        output out, out_val, out_last, overflow
    );

    modport slave (
        output in_, in_val, out_rdy,
        input  out, out_val, out_last, overflow
    );

endinterface

// File: rtl/sort_vec_fifo.sv
// Whole-vector FIFO with registered head; a push while full is taken when the
// same cycle also pops, so a full FIFO keeps streaming without drops.
module sort_vec_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_data_o
);

    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam int unsigned     CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign do_pop      = pop_i & ~empty_o;
    assign do_push     = push_i & (~full_o | do_pop);
    assign head_data_o = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/sort_out_serializer.sv
// Buffers sorted vectors and streams their elements ascending over val/rdy.
// Optional SORT_SER_ORDER_CHECK_EN adds a sticky order_err output.
module sort_out_serializer
    import sort_pkg::*;
#(
    parameter int unsigned nbits = SORT_NBITS,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sort_out_serializer_if.master bus
`ifdef SORT_SER_ORDER_CHECK_EN
    ,
    output logic                  order_err
`endif
);

    localparam int unsigned VEC_W = SORT_NELEMS * nbits;

    logic [VEC_W-1:0] head_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             xfer;
    logic             pop_vec;
    logic             accept;
    logic             push;
    logic             drop;
    elem_idx_e        idx_q, idx_d;
    logic             overflow_q, overflow_d;

    sort_vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (bus.in_),
        .pop_i       (pop_vec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_data_o (head_data)
    );

    assign xfer    = ~fifo_empty & bus.out_rdy;
    assign pop_vec = xfer & (idx_q == ELEM3);
    assign accept  = ~fifo_full | pop_vec;
    assign push    = bus.in_val & accept;
    assign drop    = bus.in_val & ~accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= ELEM0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        overflow_d = overflow_q | drop;
        if (xfer) begin
            idx_d = (idx_q == ELEM3) ? ELEM0 : elem_idx_e'(idx_q + 2'd1);
        end
    end

    always_comb begin
        bus.out = '0;
        for (int unsigned i = 0; i < SORT_NELEMS; i++) begin
            if (32'(idx_q) == i) bus.out = head_data[(SORT_NELEMS-1-i)*nbits +: nbits];
        end
        bus.out_val  = ~fifo_empty;
        bus.out_last = ~fifo_empty & (idx_q == ELEM3);
        bus.overflow = overflow_q;
    end

`ifdef SORT_SER_ORDER_CHECK_EN
    logic in_ordered;
    logic order_err_q, order_err_d;

    // Only vectors that actually enter the FIFO are checked.
    always_comb begin
        in_ordered = 1'b1;
        for (int unsigned i = 0; i < SORT_NELEMS - 1; i++) begin
            if (bus.in_[(SORT_NELEMS-1-i)*nbits +: nbits] > bus.in_[(SORT_NELEMS-2-i)*nbits +: nbits])
                in_ordered = 1'b0;
        end
        order_err_d = order_err_q | (push & ~in_ordered);
    end

    always_ff @(posedge clk) begin
        if (reset) order_err_q <= 1'b0;
        else       order_err_q <= order_err_d;
    end

    assign order_err = order_err_q;
`endif

endmodule
